iot_event_encoder: RTL
======================

# iot_event_encoder

Transmitter side of the active-device monitor link. Watches a bank of N_DEV per-device activity lines and turns every net state change into a single `change`/`on_off` event per clock, so the downstream monitor counter sees each device turn-on/turn-off exactly once. Transitions that arrive at the same time are buffered and sent out one at a time using round-robin order. A shadow count of the reported active devices is kept so it can be cross-checked against the monitor's `counter_out`.

## Interface
Parameters:
- N_DEV, 8: number of monitored devices; legal range 2..255.
- ID_W, $clog2(N_DEV): width of the device index. Derived; never overridden.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  1 = emission allowed; 0 = hold; transitions keep accumulating.
- dev_active  in  N_DEV  per-device activity level; synchronous to clk.
- change  out  1  one-cycle event strobe to monitor.
- on_off  out  1  event direction: 1 = device turned on (monitor counts up), 0 = device turned off (counts down). Valid only while change=1; otherwise 0.
- dev_id  out  ID_W  index of the device in the current event; holds last value when change=0.
- backlog  out  ID_W+1  number of devices with an unreported state.
- shadow_count  out  8  population count of the reported-state vector (what the monitor should now hold).

## Operation
- Registers:
  - `state[N_DEV]`: sampled dev_active.
  - `rep[N_DEV]`: state last reported to the monitor.
  - `ptr[ID_W]`: round-robin start index.
  - All outputs are registered.
- Pending vector: `pend = state ^ rep`, computed combinationally.
- Each edge:
  - `state <= dev_active`.
  - If enable=1 and pend≠0, grant the first set bit at or after ptr, searching cyclically with wrap at N_DEV-1→0. Call it g.
  - On a grant:
    - `change<=1`, `on_off<=state[g]`, `dev_id<=g`.
    - `rep[g]<=state[g]`.
    - `ptr<=(g==N_DEV-1)?0:g+1`.
  - With no grant: `change<=0`, `on_off<=0`; dev_id and ptr hold.
- Glitch cancel: if a device toggles and returns before it is granted, pend clears and no event is sent. This is required behaviour.
- Same-edge conflict: grant g uses the pre-edge `state[g]`. If dev_active[g] differs at that same edge, pend[g] re-asserts next cycle with the opposite direction. No event is ever lost.
- backlog = popcount(pend), registered (value reflects pend after the edge).
- shadow_count = popcount(rep after update), registered. Range 0..N_DEV, so it never wraps.
- Reset:
  - state, rep, ptr, change, on_off, dev_id, backlog, shadow_count all <= 0.
  - Devices already active when rst drops are reported as on-events over the following cycles.
  - Reset in mid-burst discards all pending events.

## Timing
- Latency: a dev_active change sampled at edge k raises change after edge k+1, provided no other device is pending ahead of it.
- Throughput: one event per cycle. Worst-case drain is N_DEV cycles after the inputs go quiet.
- Fairness: any pending device is granted within N_DEV cycles of enable=1.
- change is never high for two consecutive cycles with the same dev_id and the same on_off.
- enable=0 takes effect at the next edge: change is 0 in the following cycle.

## Structure
- Shared package `iot_pkg`:
  - N_DEV_DEFAULT = 8.
  - Event direction constants EV_OFF=0, EV_ON=1.
  - Popcount function, shared with monitor checkers.
- Sub-module `rr_arbiter` (N, inputs req/ptr, outputs gnt_valid/gnt_idx), combinational. Keeps the cyclic search separate from the state registers.

## Test plan
- Reset/idle: rst=1 for 2 cycles with dev_active=8'hFF, then rst=0.
  - Required: change=0 and shadow_count=0 during reset.
  - Then 8 consecutive events, dev_id 0..7, on_off=1.
  - shadow_count ends at 8; backlog goes 8→0.
- Simultaneous fall: from all-on, dev_active=8'h00 in one cycle.
  - Required: 8 events with on_off=0.
  - Grant order starts at ptr (0 after the previous drain): 0,1,…,7.
  - shadow_count 8→0.
- Glitch cancel: enable=0, device 3 pulses high for 3 cycles, then enable=1.
  - Required: no change pulse; backlog rose to 1 and returned to 0.
- Same-edge conflict: device 5 granted on-event while dev_active[5] drops at that edge.
  - Required: next cycle an event with dev_id=5, on_off=0; net shadow_count unchanged.
- Round-robin wrap: ptr=6, pending {1,6,7}.
  - Required: grant order 6,7,1; ptr ends at 2.
- Reset mid-burst: assert rst with backlog=5.
  - Required: change=0 the next cycle, all counters 0.
  - After release with dev_active stable, re-report only the currently active devices.

Source files
------------

// File: rtl/iot_pkg.sv
`default_nettype none
// ============================================================================
// Module   : iot_pkg
// Brief    : Shared constants and helpers for the active-device monitor link.
// Revision : 1.0 - initial release
// ============================================================================
package iot_pkg;

    localparam int N_DEV_DEFAULT = 8;

    localparam logic EV_OFF = 1'b0;
    localparam logic EV_ON  = 1'b1;

    // Callers zero-extend their vector to 256 bits; unused upper bits cost nothing.
    function automatic int unsigned popcount(input logic [255:0] v);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            cnt = cnt + {31'b0, v[i]};
        end
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/iot_event_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : iot_event_encoder_if
// Brief    : Activity inputs and event/status outputs of the event encoder.
// Revision : 1.0 - initial release
// ============================================================================
interface iot_event_encoder_if
    import iot_pkg::*;
#(
    parameter int N_DEV = N_DEV_DEFAULT
);
    localparam int ID_W = $clog2(N_DEV);

    logic               enable;
    logic [N_DEV-1:0]   dev_active;
    logic               change;
    logic               on_off;
    logic [ID_W-1:0]    dev_id;
    logic [ID_W:0]      backlog;
    logic [7:0]         shadow_count;

    modport master (
        output enable, dev_active,
        input  change, on_off, dev_id, backlog, shadow_count
    );

    modport slave (
        input  enable, dev_active,
        output change, on_off, dev_id, backlog, shadow_count
    );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin search for the first request at or
//            after ptr, wrapping from N-1 back to 0.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter  int N    = 8,
    localparam int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic            gnt_valid,
    output logic [ID_W-1:0] gnt_idx
);

    logic [ID_W:0] w_cand;

    // Walk offsets from farthest to nearest so the nearest request wins last.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        w_cand    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            w_cand = {1'b0, ptr} + (ID_W+1)'(i);
            if (w_cand >= (ID_W+1)'(N)) begin
                w_cand = w_cand - (ID_W+1)'(N);
            end
            if (req[w_cand[ID_W-1:0]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = w_cand[ID_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/iot_event_encoder.sv
`default_nettype none
// ============================================================================
// Module   : iot_event_encoder
// Brief    : Serialises per-device activity changes into one on/off event per
//            clock, round-robin, with backlog and shadow active-count outputs.
// Revision : 1.0 - initial release
// ============================================================================
module iot_event_encoder
    import iot_pkg::*;
#(
    parameter int N_DEV = N_DEV_DEFAULT
) (
    input  wire logic           clk,
    input  wire logic           rst,
    iot_event_encoder_if.slave  bus
);

    localparam int ID_W = $clog2(N_DEV);

    logic [N_DEV-1:0]   r_state;
    logic [N_DEV-1:0]   r_rep;
    logic [ID_W-1:0]    r_ptr;
    logic               r_change;
    logic               r_on_off;
    logic [ID_W-1:0]    r_dev_id;
    logic [ID_W:0]      r_backlog;
    logic [7:0]         r_shadow;

    logic [N_DEV-1:0]   w_pend;
    logic [N_DEV-1:0]   w_rep_next;
    logic [N_DEV-1:0]   w_pend_next;
    logic               w_gnt_valid;
    logic [ID_W-1:0]    w_gnt_idx;
    logic               w_grant;

    assign w_pend = r_state ^ r_rep;

    rr_arbiter #(
        .N          (N_DEV)
    ) u_arb (
        .req        (w_pend),
        .ptr        (r_ptr),
        .gnt_valid  (w_gnt_valid),
        .gnt_idx    (w_gnt_idx)
    );

    assign w_grant = bus.enable & w_gnt_valid;

    always_comb begin
        w_rep_next = r_rep;
        if (w_grant) begin
            w_rep_next[w_gnt_idx] = r_state[w_gnt_idx];
        end
    end

    // Backlog reflects the pending set as it will look after this edge.
    assign w_pend_next = bus.dev_active ^ w_rep_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= '0;
            r_rep     <= '0;
            r_ptr     <= '0;
            r_change  <= 1'b0;
            r_on_off  <= EV_OFF;
            r_dev_id  <= '0;
            r_backlog <= '0;
            r_shadow  <= '0;
        end else begin
            r_state   <= bus.dev_active;
            r_rep     <= w_rep_next;
            r_backlog <= (ID_W+1)'(popcount(256'(w_pend_next)));
            r_shadow  <= 8'(popcount(256'(w_rep_next)));
            if (w_grant) begin
                r_change <= 1'b1;
                r_on_off <= r_state[w_gnt_idx] ? EV_ON : EV_OFF;
                r_dev_id <= w_gnt_idx;
                r_ptr    <= (w_gnt_idx == ID_W'(N_DEV - 1)) ? '0 : w_gnt_idx + 1'b1;
            end else begin
                r_change <= 1'b0;
                r_on_off <= EV_OFF;
            end
        end
    end

    assign bus.change       = r_change;
    assign bus.on_off       = r_on_off;
    assign bus.dev_id       = r_dev_id;
    assign bus.backlog      = r_backlog;
    assign bus.shadow_count = r_shadow;

endmodule
`default_nettype wire
